// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tt_sweep_pkg
//  Purpose  : Shared widths and state encoding for truth-table sweepers.
//  Revision : 1.0  initial release
// ============================================================================
package tt_sweep_pkg;

    localparam int N_IN     = 7;
    localparam int TT_W     = 128;
    localparam int CNT_W    = 8;   // holds 0..TT_W inclusive
    localparam int SETTLE_W = 4;   // SETTLE range 0..15

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage : tt_sweep_pkg
`default_nettype wire

// File: rtl/tt_sweep_capture_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : settle_timer
//  Purpose  : Loadable down-counter; fire is high once the count reaches zero.
//  Revision : 1.0  initial release
// ============================================================================
module settle_timer
    import tt_sweep_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                fire
);

    logic [SETTLE_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign fire = (r_cnt == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/tt_sweep_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tt_sweep_capture
//  Purpose  : Sweeps a 7-input network through all vectors, captures its truth
//             table and scores it against a reference table.
//  Revision : 1.0  initial release
// ============================================================================
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TT_W-1:0]  expected,
    input  logic             dut_out,
    output logic [N_IN-1:0]  x,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [TT_W-1:0]  tt,
    output logic             match,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [N_IN-1:0]  first_mismatch,
    output logic             has_mismatch
);

    localparam logic [SETTLE_W-1:0] c_settle   = SETTLE_W'(SETTLE);
    localparam logic [N_IN-1:0]     c_last_idx = N_IN'(TT_W - 1);

    sweep_state_t     r_state;
    sweep_state_t     w_state_next;
    logic [TT_W-1:0]  r_exp;
    logic [TT_W-1:0]  r_tt;
    logic [N_IN-1:0]  r_x;
    logic [CNT_W-1:0] r_mismatch_cnt;
    logic [N_IN-1:0]  r_first_mismatch;
    logic             r_has_mismatch;
    logic             r_match;
    logic             r_valid;
    logic             r_done;

    logic             w_fire;
    logic             w_accept;
    logic             w_sample;
    logic             w_last;
    logic             w_diff;
    logic [CNT_W-1:0] w_cnt_next;

    // Reloaded at sweep start and after every non-final sample, so each vector
    // is held for exactly SETTLE+1 edges.
    settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept | (w_sample & ~w_last)),
        .en       (r_state == SWEEP),
        .load_val (c_settle),
        .fire     (w_fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (w_fire) begin
                    w_sample = 1'b1;
                    if (r_x == c_last_idx) begin
                        w_last       = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_diff     = dut_out ^ r_exp[r_x];
    assign w_cnt_next = r_mismatch_cnt + {{(CNT_W-1){1'b0}}, w_diff};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp            <= '0;
            r_tt             <= '0;
            r_x              <= '0;
            r_mismatch_cnt   <= '0;
            r_first_mismatch <= '0;
            r_has_mismatch   <= 1'b0;
            r_match          <= 1'b0;
            r_valid          <= 1'b0;
            r_done           <= 1'b0;
        end else if (w_accept) begin
            r_exp            <= expected;
            r_tt             <= '0;
            r_x              <= '0;
            r_mismatch_cnt   <= '0;
            r_first_mismatch <= '0;
            r_has_mismatch   <= 1'b0;
            r_match          <= 1'b0;
            r_valid          <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_sample) begin
                r_tt[r_x]      <= dut_out;
                r_mismatch_cnt <= w_cnt_next;
                if (w_diff && !r_has_mismatch) begin
                    r_first_mismatch <= r_x;
                    r_has_mismatch   <= 1'b1;
                end
                // Final verdict includes the compare made on this same edge.
                if (w_last) begin
                    r_valid <= 1'b1;
                    r_match <= (w_cnt_next == '0);
                end else begin
                    r_x <= r_x + 7'd1;
                end
            end
        end
    end

    assign x              = r_x;
    assign busy           = (r_state == SWEEP);
    assign done           = r_done;
    assign valid          = r_valid;
    assign tt             = r_tt;
    assign match          = r_match;
    assign mismatch_cnt   = r_mismatch_cnt;
    assign first_mismatch = r_first_mismatch;
    assign has_mismatch   = r_has_mismatch;

endmodule : tt_sweep_capture
`default_nettype wire
